// File: rtl/riscv_pkg.sv
// Shared types for the IF/LSU memory arbiter: access sizes, arbiter states and
// bus owner encoding.
package riscv_pkg;

  localparam int XLEN   = 32;
  localparam int NBYTES = XLEN / 8;

  // Low address bits are dropped on the bus; accesses are always word-addressed.
  localparam logic [XLEN-1:0] WORD_ADDR_MASK = ~XLEN'(3);

  typedef enum logic [1:0] {
    BYTE    = 2'b00,
    HALF    = 2'b01,
    WORD    = 2'b10,
    ILLEGAL = 2'b11
  } mem_size_e;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    ERR
  } arb_state_e;

  typedef enum logic {
    OWN_IF,
    OWN_LSU
  } owner_e;

endpackage

// File: rtl/riscv_mem_arbiter_if.sv
// Signal bundle for the arbiter: fetch port, load/store port and memory bus.
// The arbiter uses the slave view; the surrounding core/memory use master.
interface riscv_mem_arbiter_if;
  import riscv_pkg::*;

  logic              if_req_i;
  logic [XLEN-1:0]   if_addr_i;
  logic              if_gnt_o;
  logic              if_rvalid_o;
  logic [XLEN-1:0]   if_rdata_o;

  logic              lsu_req_i;
  logic              lsu_we_i;
  logic [XLEN-1:0]   lsu_addr_i;
  logic [XLEN-1:0]   lsu_wdata_i;
  logic [1:0]        lsu_size_i;
  logic              lsu_unsigned_i;
  logic              lsu_gnt_o;
  logic              lsu_rvalid_o;
  logic [XLEN-1:0]   lsu_rdata_o;
  logic              lsu_err_o;

  logic              mem_req_o;
  logic              mem_we_o;
  logic [XLEN-1:0]   mem_addr_o;
  logic [NBYTES-1:0] mem_be_o;
  logic [XLEN-1:0]   mem_wdata_o;
  logic              mem_gnt_i;
  logic              mem_rvalid_i;
  logic [XLEN-1:0]   mem_rdata_i;

  modport slave (
    input  if_req_i, if_addr_i,
    output if_gnt_o, if_rvalid_o, if_rdata_o,
    input  lsu_req_i, lsu_we_i, lsu_addr_i, lsu_wdata_i, lsu_size_i, lsu_unsigned_i,
    output lsu_gnt_o, lsu_rvalid_o, lsu_rdata_o, lsu_err_o,
    output mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o,
    input  mem_gnt_i, mem_rvalid_i, mem_rdata_i
  );

  modport master (
    output if_req_i, if_addr_i,
    input  if_gnt_o, if_rvalid_o, if_rdata_o,
    output lsu_req_i, lsu_we_i, lsu_addr_i, lsu_wdata_i, lsu_size_i, lsu_unsigned_i,
    input  lsu_gnt_o, lsu_rvalid_o, lsu_rdata_o, lsu_err_o,
    input  mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o,
    output mem_gnt_i, mem_rvalid_i, mem_rdata_i
  );

endinterface

// File: rtl/riscv_lsu_align.sv
// Combinational lane logic: alignment check, store byte enables and data
// replication, and load lane extraction with sign/zero extension.
module riscv_lsu_align
  import riscv_pkg::*;
(
  input  logic [1:0]        i_offset,
  input  mem_size_e         i_size,
  input  logic              i_unsigned,
  input  logic [XLEN-1:0]   i_wdata,
  input  logic [XLEN-1:0]   i_rdata,
  output logic              o_misaligned,
  output logic [NBYTES-1:0] o_be,
  output logic [XLEN-1:0]   o_wdata,
  output logic [XLEN-1:0]   o_rdata
);

  logic [15:0] w_lane;

  // Addressed byte/half is moved down to bit 0 before extension.
  assign w_lane = 16'(i_rdata >> {i_offset, 3'b000});

  always_comb begin
    // NOTE: every output gets a default first so no path through the case can infer a latch.
    o_misaligned = 1'b0;
    o_be         = 4'b1111;
    o_wdata      = i_wdata;
    o_rdata      = i_rdata;
    case (i_size)
      BYTE: begin
        o_be    = 4'b0001 << i_offset;
        o_wdata = {4{i_wdata[7:0]}};
        o_rdata = i_unsigned ? {24'b0, w_lane[7:0]} : {{24{w_lane[7]}}, w_lane[7:0]};
      end
      HALF: begin
        o_misaligned = i_offset[0];
        o_be         = 4'b0011 << i_offset;
        o_wdata      = {2{i_wdata[15:0]}};
        o_rdata      = i_unsigned ? {16'b0, w_lane} : {{16{w_lane[15]}}, w_lane};
      end
      WORD:    o_misaligned = |i_offset;
      default: o_misaligned = 1'b1;
    endcase
  end

endmodule

// File: rtl/riscv_mem_arbiter.sv
// Single-port memory arbiter: LSU has fixed priority over instruction fetch,
// one transaction outstanding, misaligned LSU accesses answered locally.
module riscv_mem_arbiter
  import riscv_pkg::*;
(
  input logic                clk_i,
  input logic                rst_ni,
  riscv_mem_arbiter_if.slave bus
);

  arb_state_e        r_state, w_state_nxt;
  owner_e            r_owner;
  logic              r_we, r_unsigned;
  logic [XLEN-1:0]   r_addr, r_wdata;
  mem_size_e         r_size;
  logic [NBYTES-1:0] r_be;
  logic              r_if_rvalid, r_lsu_rvalid;
  logic [XLEN-1:0]   r_if_rdata, r_lsu_rdata;

  logic              w_if_gnt, w_lsu_gnt, w_done;
  logic [1:0]        w_al_offset;
  mem_size_e         w_al_size;
  logic              w_misaligned;
  logic [NBYTES-1:0] w_al_be;
  logic [XLEN-1:0]   w_al_wdata, w_al_rdata;

  // One aligner serves both paths: live LSU fields while arbitrating, latched
  // fields while the load response is being formatted.
  assign w_al_offset = (r_state == IDLE) ? bus.lsu_addr_i[1:0] : r_addr[1:0];
  assign w_al_size   = (r_state == IDLE) ? mem_size_e'(bus.lsu_size_i) : r_size;

  riscv_lsu_align u_align (
    .i_offset     (w_al_offset),
    .i_size       (w_al_size),
    .i_unsigned   (r_unsigned),
    .i_wdata      (bus.lsu_wdata_i),
    .i_rdata      (bus.mem_rdata_i),
    .o_misaligned (w_misaligned),
    .o_be         (w_al_be),
    .o_wdata      (w_al_wdata),
    .o_rdata      (w_al_rdata)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_if_gnt    = 1'b0;
    w_lsu_gnt   = 1'b0;
    case (r_state)
      IDLE: begin
        if (rst_ni && bus.lsu_req_i) begin
          w_lsu_gnt   = 1'b1;
          w_state_nxt = w_misaligned ? ERR : REQ;
        end else if (rst_ni && bus.if_req_i) begin
          w_if_gnt    = 1'b1;
          w_state_nxt = REQ;
        end
      end
      REQ:     if (bus.mem_gnt_i)    w_state_nxt = WAIT;
      WAIT:    if (bus.mem_rvalid_i) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_done = (r_state == WAIT) && bus.mem_rvalid_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (!rst_ni) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_owner    <= OWN_IF;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_size     <= BYTE;
      r_unsigned <= 1'b0;
      r_be       <= '0;
      r_wdata    <= '0;
    end else if (w_lsu_gnt) begin
      r_owner    <= OWN_LSU;
      r_we       <= bus.lsu_we_i;
      r_addr     <= bus.lsu_addr_i;
      r_size     <= w_al_size;
      r_unsigned <= bus.lsu_unsigned_i;
      r_be       <= w_al_be;
      r_wdata    <= bus.lsu_we_i ? w_al_wdata : '0;
    end else if (w_if_gnt) begin
      r_owner    <= OWN_IF;
      r_we       <= 1'b0;
      r_addr     <= bus.if_addr_i & WORD_ADDR_MASK;
      r_size     <= WORD;
      r_unsigned <= 1'b0;
      r_be       <= '1;
      r_wdata    <= '0;
    end
  end

  // Response registers are single-cycle pulses; data returns to 0 when idle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_if_rvalid  <= 1'b0;
      r_lsu_rvalid <= 1'b0;
      r_if_rdata   <= '0;
      r_lsu_rdata  <= '0;
    end else begin
      r_if_rvalid  <= 1'b0;
      r_lsu_rvalid <= 1'b0;
      r_if_rdata   <= '0;
      r_lsu_rdata  <= '0;
      if (w_done) begin
        if (r_owner == OWN_IF) begin
          r_if_rvalid <= 1'b1;
          r_if_rdata  <= bus.mem_rdata_i;
        end else begin
          r_lsu_rvalid <= 1'b1;
          r_lsu_rdata  <= r_we ? '0 : w_al_rdata;
        end
      end
    end
  end

  assign bus.if_gnt_o     = w_if_gnt;
  assign bus.if_rvalid_o  = r_if_rvalid;
  assign bus.if_rdata_o   = r_if_rdata;
  assign bus.lsu_gnt_o    = w_lsu_gnt;
  assign bus.lsu_rvalid_o = r_lsu_rvalid | (r_state == ERR);
  assign bus.lsu_err_o    = (r_state == ERR);
  assign bus.lsu_rdata_o  = r_lsu_rdata;
  assign bus.mem_req_o    = (r_state == REQ);
  assign bus.mem_we_o     = r_we;
  assign bus.mem_addr_o   = r_addr & WORD_ADDR_MASK;
  assign bus.mem_be_o     = r_be;
  assign bus.mem_wdata_o  = r_wdata;

endmodule
